// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - F-stage program counter, next-PC select and F/D pipeline register
// The delay slot is never squashed, so a redirect only steers F_pc and D takes whatever F fetched.
module fetch_pc_unit #(
    parameter logic [31:0] PC_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] F_instr,
    input  logic [1:0]  D_npc_op,
    input  logic        D_br_taken,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_imm26,
    input  logic [31:0] D_rs_data,
    output logic [31:0] F_pc,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic        D_adel,
    output logic        D_valid
);

    localparam logic [31:0] PC_LAST = PC_BASE + (32'(IM_WORDS) << 2) - 32'd4;

    localparam logic [1:0] NPC_SEQ    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JREG   = 2'd3;

    logic [31:0] npc;
    logic [31:0] br_offset;
    logic        f_pc_legal;

    assign br_offset  = {{14{D_imm16[15]}}, D_imm16, 2'b00};
    assign f_pc_legal = (F_pc[1:0] == 2'b00) && (F_pc >= PC_BASE) && (F_pc <= PC_LAST);

    always_comb begin
        npc = F_pc + 32'd4;
        case (D_npc_op)
            NPC_SEQ:    npc = F_pc + 32'd4;
            NPC_BRANCH: npc = D_br_taken ? (D_pc + 32'd4 + br_offset) : (F_pc + 32'd4);
            NPC_JUMP:   npc = {D_pc[31:28], D_imm26, 2'b00};
            NPC_JREG:   npc = D_rs_data;
            default:    npc = F_pc + 32'd4;
        endcase
    end

    // Illegal fetches keep going sequentially; the fault is only tagged for later stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            F_pc    <= PC_BASE;
            D_pc    <= PC_BASE;
            D_instr <= 32'd0;
            D_adel  <= 1'b0;
            D_valid <= 1'b0;
        end else if (!stall) begin
            F_pc    <= npc;
            D_pc    <= F_pc;
            D_valid <= 1'b1;
            if (f_pc_legal) begin
                D_instr <= F_instr;
                D_adel  <= 1'b0;
            end else begin
                D_instr <= 32'd0;
                D_adel  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed and random checks of fetch_pc_unit against a reference model
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] F_instr;
    logic [1:0]  D_npc_op = 2'd0;
    logic        D_br_taken = 1'b0;
    logic [15:0] D_imm16 = 16'd0;
    logic [25:0] D_imm26 = 26'd0;
    logic [31:0] D_rs_data = 32'd0;
    logic [31:0] F_pc, D_pc, D_instr;
    logic        D_adel, D_valid;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_f_pc = 32'h3000, m_d_pc = 32'h3000, m_d_instr = 32'd0;
    logic        m_d_adel = 1'b0, m_d_valid = 1'b0;
    logic [31:0] save_f, save_d, save_i;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign F_instr = mem_word(F_pc);

    fetch_pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .F_instr(F_instr),
        .D_npc_op(D_npc_op), .D_br_taken(D_br_taken), .D_imm16(D_imm16),
        .D_imm26(D_imm26), .D_rs_data(D_rs_data), .F_pc(F_pc), .D_pc(D_pc),
        .D_instr(D_instr), .D_adel(D_adel), .D_valid(D_valid)
    );

    function automatic bit legal(input logic [31:0] a);
        longint unsigned u;
        u = longint'(a);
        return (u % 4 == 0) && (u >= 64'h3000) && (u <= 64'h3000 + 4 * 4096 - 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic [1:0] op, input logic tk,
                       input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rs);
        logic [31:0] target, off;
        reset = r; stall = s; D_npc_op = op; D_br_taken = tk;
        D_imm16 = i16; D_imm26 = i26; D_rs_data = rs;
        off = {{16{i16[15]}}, i16};
        if (op == 2'd1 && tk)  target = m_d_pc + 32'd4 + off * 32'd4;
        else if (op == 2'd2)   target = (m_d_pc & 32'hF000_0000) | (32'(i26) * 32'd4);
        else if (op == 2'd3)   target = rs;
        else                   target = m_f_pc + 32'd4;
        @(posedge clk);
        #1;
        if (r) begin
            m_f_pc = 32'h3000; m_d_pc = 32'h3000; m_d_instr = 32'd0;
            m_d_adel = 1'b0; m_d_valid = 1'b0;
        end else if (!s) begin
            m_d_instr = legal(m_f_pc) ? mem_word(m_f_pc) : 32'd0;
            m_d_adel  = !legal(m_f_pc);
            m_d_pc    = m_f_pc;
            m_f_pc    = target;
            m_d_valid = 1'b1;
        end
        check("f_pc", F_pc, m_f_pc);
        check("d_pc", D_pc, m_d_pc);
        check("d_instr", D_instr, m_d_instr);
        check("d_adel", 32'(D_adel), 32'(m_d_adel));
        check("d_valid", 32'(D_valid), 32'(m_d_valid));
    endtask

    task automatic seq(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
    endtask

    initial begin
        // reset and free run
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
        check("rst_f_pc", F_pc, 32'h3000);
        check("rst_valid", 32'(D_valid), 32'd0);
        check("rst_instr", D_instr, 32'd0);
        seq(1);
        check("run_f_pc", F_pc, 32'h3004);
        check("run_d_pc", D_pc, 32'h3000);
        check("run_instr", D_instr, mem_word(32'h3000));
        seq(2);
        check("run2_f_pc", F_pc, 32'h300C);
        seq(2);
        check("pre_beq_d_pc", D_pc, 32'h3010);

        // taken and not-taken branch
        cyc(1'b0, 1'b0, 2'd1, 1'b1, 16'hFFFC, 26'd0, 32'd0);
        check("beq_f_pc", F_pc, 32'h3004);
        check("beq_slot_d_pc", D_pc, 32'h3014);
        seq(4);
        cyc(1'b0, 1'b0, 2'd1, 1'b0, 16'hFFFC, 26'd0, 32'd0);
        check("bnt_f_pc", F_pc, 32'h3018);

        // j and jr
        seq(3);
        check("pre_j_d_pc", D_pc, 32'h3020);
        cyc(1'b0, 1'b0, 2'd2, 1'b0, 16'd0, 26'h0000C40, 32'd0);
        check("j_f_pc", F_pc, 32'h3100);
        cyc(1'b0, 1'b0, 2'd3, 1'b0, 16'd0, 26'd0, 32'h3200);
        check("jr_f_pc", F_pc, 32'h3200);

        // stall across a jump redirect
        save_f = F_pc; save_d = D_pc; save_i = D_instr;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 2'd2, 1'b0, 16'd0, 26'h0000D00, 32'd0);
            check("stall_f_pc", F_pc, save_f);
            check("stall_d_pc", D_pc, save_d);
            check("stall_instr", D_instr, save_i);
        end
        cyc(1'b0, 1'b0, 2'd2, 1'b0, 16'd0, 26'h0000D00, 32'd0);
        check("unstall_f_pc", F_pc, 32'h3400);

        // address errors at and around the legal bounds
        cyc(1'b0, 1'b0, 2'd3, 1'b0, 16'd0, 26'd0, 32'h3002);
        seq(1);
        check("adel_mis_flag", 32'(D_adel), 32'd1);
        check("adel_mis_instr", D_instr, 32'd0);
        check("adel_mis_d_pc", D_pc, 32'h3002);
        cyc(1'b0, 1'b0, 2'd3, 1'b0, 16'd0, 26'd0, 32'h7000);
        seq(1);
        check("adel_hi_flag", 32'(D_adel), 32'd1);
        check("adel_hi_instr", D_instr, 32'd0);
        cyc(1'b0, 1'b0, 2'd3, 1'b0, 16'd0, 26'd0, 32'h6FFC);
        seq(1);
        check("last_ok_flag", 32'(D_adel), 32'd0);
        check("last_ok_instr", D_instr, mem_word(32'h6FFC));
        cyc(1'b0, 1'b0, 2'd3, 1'b0, 16'd0, 26'd0, 32'h2FFC);
        seq(1);
        check("adel_lo_flag", 32'(D_adel), 32'd1);

        // reset during stall and redirect
        cyc(1'b1, 1'b1, 2'd3, 1'b0, 16'd0, 26'd0, 32'h5000);
        check("rst_stall_f_pc", F_pc, 32'h3000);
        check("rst_stall_instr", D_instr, 32'd0);
        check("rst_stall_valid", 32'(D_valid), 32'd0);

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [31:0] rs;
            rs = ($urandom_range(0, 3) == 0) ? $urandom : (32'h3000 + 32'($urandom_range(0, 4200)) * 4);
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                16'($urandom), 26'($urandom_range(32'h0C00, 32'h1C00)), rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- F-stage front end of the five-stage MIPS pipeline.
- Holds the program counter `F_pc`, which drives the instruction memory address.
- Computes the next PC from the D-stage control-transfer decision, using branch-delay-slot semantics.
- Owns the F/D pipeline register, which latches the fetched instruction, its PC and an address-error flag into D; honours stall from the hazard unit.

Parameters:
- PC_BASE, 32'h0000_3000, reset PC and lowest legal fetch address.
- IM_WORDS, 4096, instruction memory depth in words; legal fetch range is PC_BASE .. PC_BASE+4*IM_WORDS-4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit stall; freezes F_pc and the F/D register.
- F_instr  input  32  instruction word returned by instruction memory for F_pc.
- D_npc_op  input  2  D-stage next-PC select: 0 sequential, 1 branch, 2 j/jal, 3 jr/jalr.
- D_br_taken  input  1  branch comparison result for the D instruction (only meaningful when D_npc_op=1).
- D_imm16  input  16  branch offset field of the D instruction.
- D_imm26  input  26  jump index field of the D instruction.
- D_rs_data  input  32  forwarded rs value for jr/jalr.
- F_pc  output  32  current fetch address to instruction memory.
- D_pc  output  32  PC of the instruction held in D.
- D_instr  output  32  instruction held in D.
- D_adel  output  1  fetch address error for the instruction held in D.
- D_valid  output  1  D holds a fetched instruction (0 only after reset until first advance).

Behaviour:
- **Reset** (reset=1 at posedge, overrides stall): F_pc=PC_BASE, D_pc=PC_BASE, D_instr=0 (nop), D_adel=0, D_valid=0.
- **Next-PC**, combinational, all 32-bit, wrap modulo 2^32:
  - op0, or op1 with D_br_taken=0: npc = F_pc+4.
  - op1 with D_br_taken=1: npc = D_pc+4+(sext(D_imm16)<<2).
  - op2: npc = {D_pc[31:28], D_imm26, 2'b00}.
  - op3: npc = D_rs_data, unmodified (no alignment forcing).
- **Delay slot:** when a branch or jump is in D, F already holds D_pc+4. That instruction is fetched normally and never squashed; no flush path exists.
- **Advance** (reset=0, stall=0) at posedge:
  - F_pc <= npc, D_pc <= F_pc, D_valid <= 1.
  - If F_pc is legal: D_instr <= F_instr, D_adel <= 0.
  - If F_pc is illegal: D_instr <= 0, D_adel <= 1.
- **Legal F_pc:** F_pc[1:0]==0 and PC_BASE <= F_pc <= PC_BASE+4*IM_WORDS-4. The comparison is unsigned, with 32-bit bounds.
- **Stall** (reset=0, stall=1): all registers hold. The D_npc_op redirect is ignored that cycle; it is re-presented while D is held and takes effect on the first non-stall edge.
- **Stall and redirect in the same cycle:** stall wins.
- **Reset in the middle of a stall or redirect:** reset wins. There is no pending state beyond the registers.
- **Latency:** F_pc to D_instr/D_pc is exactly one non-stalled cycle. A redirect reaches F_pc one edge after the branch enters D.
- **Illegal F_pc is not trapped here.** Fetch continues sequentially from the illegal address, and each illegal fetch is tagged D_adel=1.
- **F_pc outputs** come directly from registers; no combinational path from inputs to F_pc.

Test Plan:
1. **Reset then free run:** reset 1 cycle, stall=0, op=0.
   - First post-reset edge: F_pc 0x3004, D_pc 0x3000, D_valid=1, D_instr = word at 0x3000.
   - Two edges later: F_pc = 0x300C.
2. **Taken beq:** D_pc=0x3010, op=1, taken=1, imm16=0xFFFC.
   - npc = 0x3004; the delay slot at 0x3014 enters D; F_pc = 0x3004 the following edge.
   - Repeat with taken=0: F_pc = 0x3018.
3. **j and jr:**
   - D_pc=0x3020, op=2, imm26=0x0000C40: F_pc becomes 0x00003100.
   - op=3, D_rs_data=0x3200: F_pc becomes 0x3200.
4. **Stall during redirect:**
   - op=2 with stall=1 for 3 cycles: F_pc, D_pc, D_instr are unchanged each cycle.
   - On the first stall=0 edge: F_pc equals the jump target.
5. **Address error:**
   - jr to 0x3002: next edge D_adel=1, D_instr=0, D_pc=0x3002.
   - jr to 0x7000: same result.
   - jr to 0x6FFC: D_adel=0.
6. **Reset mid-stall:** stall=1 and reset=1 together → F_pc 0x3000, D_instr 0, D_valid 0 on that edge.
